spi_fifo_pair: RTL and testbench

//  Paired TX/RX FIFOs between the CPU-side register interface and the SPI shift engine.
//  TX FIFO: core writes, SPI engine reads. RX FIFO: SPI engine writes, core reads.

---
 rtl/spi_fifo_pair_if.sv | 50 +++++
 rtl/spi_fifo_pair.sv | 122 ++++++++++++
 tb/tb_spi_fifo_pair.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_fifo_pair_if.sv
// Handshake, data and status bundle between the CPU/SPI sides and the paired TX/RX FIFOs.
// The slave modport is the FIFO pair; the master modport is whatever drives it.
interface spi_fifo_pair_if #(
  parameter int DATAWIDTH = 8,
  parameter int TXDEPTH   = 16,
  parameter int RXDEPTH   = 16
);
  localparam int TXCW = $clog2(TXDEPTH) + 1;
  localparam int RXCW = $clog2(RXDEPTH) + 1;

  logic                 coreTxWrite;
  logic [DATAWIDTH-1:0] coreTxData;
  logic                 spiTxRead;
  logic [DATAWIDTH-1:0] spiTxData;
  logic                 spiRxWrite;
  logic [DATAWIDTH-1:0] spiRxData;
  logic                 coreRxRead;
  logic [DATAWIDTH-1:0] coreRxData;
  logic                 txFlush;
  logic                 rxFlush;
  logic                 errClear;
  logic [TXCW-1:0]      txCount;
  logic [RXCW-1:0]      rxCount;
  logic                 txFull;
  logic                 txEmpty;
  logic                 txAlmostEmpty;
  logic                 rxFull;
  logic                 rxEmpty;
  logic                 rxAlmostFull;
  logic                 txOverflow;
  logic                 txUnderflow;
  logic                 rxOverflow;
  logic                 rxUnderflow;

  modport master (
    output coreTxWrite, coreTxData, spiTxRead, spiRxWrite, spiRxData, coreRxRead,
           txFlush, rxFlush, errClear,
    input  spiTxData, coreRxData, txCount, rxCount,
           txFull, txEmpty, txAlmostEmpty, rxFull, rxEmpty, rxAlmostFull,
           txOverflow, txUnderflow, rxOverflow, rxUnderflow
  );

  modport slave (
    input  coreTxWrite, coreTxData, spiTxRead, spiRxWrite, spiRxData, coreRxRead,
           txFlush, rxFlush, errClear,
    output spiTxData, coreRxData, txCount, rxCount,
           txFull, txEmpty, txAlmostEmpty, rxFull, rxEmpty, rxAlmostFull,
           txOverflow, txUnderflow, rxOverflow, rxUnderflow
  );
endinterface

// File: rtl/spi_fifo_pair.sv
// Paired TX/RX FIFOs between the core register interface and the SPI shift engine,
// with registered counts, watermark flags, sticky error flags and per-direction flush.
module spi_fifo_pair #(
  parameter int DATAWIDTH  = 8,
  parameter int TXDEPTH    = 16,
  parameter int RXDEPTH    = 16,
  parameter int TXLOWMARK  = 4,
  parameter int RXHIGHMARK = 12
) (
  input  logic           i_clk,
  input  logic           i_reset,
  spi_fifo_pair_if.slave bus
);
  localparam int TXAW = $clog2(TXDEPTH);
  localparam int RXAW = $clog2(RXDEPTH);
  localparam int TXCW = TXAW + 1;
  localparam int RXCW = RXAW + 1;

  logic [DATAWIDTH-1:0] r_tx_mem [TXDEPTH];
  logic [TXAW:0]        r_tx_wr_ptr, r_tx_rd_ptr;
  logic [TXCW-1:0]      r_tx_count;
  logic [DATAWIDTH-1:0] r_tx_data;
  logic                 r_tx_ovf, r_tx_unf;
  logic                 w_tx_full, w_tx_empty, w_tx_push_ok, w_tx_pop_ok;

  logic [DATAWIDTH-1:0] r_rx_mem [RXDEPTH];
  logic [RXAW:0]        r_rx_wr_ptr, r_rx_rd_ptr;
  logic [RXCW-1:0]      r_rx_count;
  logic [DATAWIDTH-1:0] r_rx_data;
  logic                 r_rx_ovf, r_rx_unf;
  logic                 w_rx_full, w_rx_empty, w_rx_push_ok, w_rx_pop_ok;

  // A push into a full FIFO still lands when a pop frees the head slot on the same edge.
  assign w_tx_full    = (r_tx_wr_ptr[TXAW-1:0] == r_tx_rd_ptr[TXAW-1:0]) &&
                        (r_tx_wr_ptr[TXAW] != r_tx_rd_ptr[TXAW]);
  assign w_tx_empty   = (r_tx_wr_ptr == r_tx_rd_ptr);
  assign w_tx_pop_ok  = bus.spiTxRead && !w_tx_empty;
  assign w_tx_push_ok = bus.coreTxWrite && (!w_tx_full || w_tx_pop_ok);

  assign w_rx_full    = (r_rx_wr_ptr[RXAW-1:0] == r_rx_rd_ptr[RXAW-1:0]) &&
                        (r_rx_wr_ptr[RXAW] != r_rx_rd_ptr[RXAW]);
  assign w_rx_empty   = (r_rx_wr_ptr == r_rx_rd_ptr);
  assign w_rx_pop_ok  = bus.coreRxRead && !w_rx_empty;
  assign w_rx_push_ok = bus.spiRxWrite && (!w_rx_full || w_rx_pop_ok);

  // NOTE: non-blocking assignments so every register samples pre-edge values, regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_count  <= '0;
      r_tx_data   <= '0;
      r_tx_ovf    <= 1'b0;
      r_tx_unf    <= 1'b0;
    end else if (bus.txFlush) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_count  <= '0;
      r_tx_ovf    <= 1'b0;
      r_tx_unf    <= 1'b0;
    end else begin
      if (w_tx_push_ok) r_tx_wr_ptr <= r_tx_wr_ptr + (TXAW+1)'(1);
      if (w_tx_pop_ok) begin
        r_tx_rd_ptr <= r_tx_rd_ptr + (TXAW+1)'(1);
        r_tx_data   <= r_tx_mem[r_tx_rd_ptr[TXAW-1:0]];
      end
      if (w_tx_push_ok && !w_tx_pop_ok)      r_tx_count <= r_tx_count + TXCW'(1);
      else if (!w_tx_push_ok && w_tx_pop_ok) r_tx_count <= r_tx_count - TXCW'(1);
      r_tx_ovf <= (bus.coreTxWrite && !w_tx_push_ok) || (r_tx_ovf && !bus.errClear);
      r_tx_unf <= (bus.spiTxRead && w_tx_empty) || (r_tx_unf && !bus.errClear);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_count  <= '0;
      r_rx_data   <= '0;
      r_rx_ovf    <= 1'b0;
      r_rx_unf    <= 1'b0;
    end else if (bus.rxFlush) begin
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_count  <= '0;
      r_rx_ovf    <= 1'b0;
      r_rx_unf    <= 1'b0;
    end else begin
      if (w_rx_push_ok) r_rx_wr_ptr <= r_rx_wr_ptr + (RXAW+1)'(1);
      if (w_rx_pop_ok) begin
        r_rx_rd_ptr <= r_rx_rd_ptr + (RXAW+1)'(1);
        r_rx_data   <= r_rx_mem[r_rx_rd_ptr[RXAW-1:0]];
      end
      if (w_rx_push_ok && !w_rx_pop_ok)      r_rx_count <= r_rx_count + RXCW'(1);
      else if (!w_rx_push_ok && w_rx_pop_ok) r_rx_count <= r_rx_count - RXCW'(1);
      r_rx_ovf <= (bus.spiRxWrite && !w_rx_push_ok) || (r_rx_ovf && !bus.errClear);
      r_rx_unf <= (bus.coreRxRead && w_rx_empty) || (r_rx_unf && !bus.errClear);
    end
  end

  // NOTE: storage arrays have no reset; the pointers alone decide which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_tx_push_ok && !bus.txFlush) r_tx_mem[r_tx_wr_ptr[TXAW-1:0]] <= bus.coreTxData;
    if (w_rx_push_ok && !bus.rxFlush) r_rx_mem[r_rx_wr_ptr[RXAW-1:0]] <= bus.spiRxData;
  end

  assign bus.spiTxData     = r_tx_data;
  assign bus.txCount       = r_tx_count;
  assign bus.txFull        = (r_tx_count == TXCW'(TXDEPTH));
  assign bus.txEmpty       = (r_tx_count == '0);
  assign bus.txAlmostEmpty = (r_tx_count <= TXCW'(TXLOWMARK));
  assign bus.txOverflow    = r_tx_ovf;
  assign bus.txUnderflow   = r_tx_unf;

  assign bus.coreRxData    = r_rx_data;
  assign bus.rxCount       = r_rx_count;
  assign bus.rxFull        = (r_rx_count == RXCW'(RXDEPTH));
  assign bus.rxEmpty       = (r_rx_count == '0);
  assign bus.rxAlmostFull  = (r_rx_count >= RXCW'(RXHIGHMARK));
  assign bus.rxOverflow    = r_rx_ovf;
  assign bus.rxUnderflow   = r_rx_unf;
endmodule

// File: tb/tb_spi_fifo_pair.sv
// Bench for spi_fifo_pair: directed scenarios followed by random traffic, every cycle
// compared against a queue-based model of both FIFOs.
module tb_spi_fifo_pair;
  localparam int DW = 8, TXD = 16, RXD = 16, TXLOW = 4, RXHIGH = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_fifo_pair_if #(.DATAWIDTH(DW), .TXDEPTH(TXD), .RXDEPTH(RXD)) bus ();

  spi_fifo_pair #(
    .DATAWIDTH(DW), .TXDEPTH(TXD), .RXDEPTH(RXD), .TXLOWMARK(TXLOW), .RXHIGHMARK(RXHIGH)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Model: index 0 = TX direction, 1 = RX direction.
  logic [DW-1:0] m_q [2][$];
  logic [DW-1:0] m_dout [2];
  logic          m_ovf [2];
  logic          m_unf [2];

  function automatic int depth_of(input int d);
    return (d == 0) ? TXD : RXD;
  endfunction

  task automatic model_dir(input int d, input logic flush, input logic push,
                           input logic [DW-1:0] din, input logic pop, input logic clr);
    logic pop_ok, push_ok;
    if (flush) begin
      m_q[d].delete();
      m_ovf[d] = 1'b0;
      m_unf[d] = 1'b0;
    end else begin
      pop_ok  = pop && (m_q[d].size() > 0);
      push_ok = push && ((m_q[d].size() < depth_of(d)) || pop_ok);
      if (pop_ok)  m_dout[d] = m_q[d].pop_front();
      if (push_ok) m_q[d].push_back(din);
      m_ovf[d] = (push && !push_ok) || (m_ovf[d] && !clr);
      m_unf[d] = (pop && !pop_ok) || (m_unf[d] && !clr);
    end
  endtask

  task automatic idle();
    bus.coreTxWrite = 1'b0; bus.coreTxData = '0; bus.spiTxRead  = 1'b0;
    bus.spiRxWrite  = 1'b0; bus.spiRxData  = '0; bus.coreRxRead = 1'b0;
    bus.txFlush = 1'b0; bus.rxFlush = 1'b0; bus.errClear = 1'b0;
  endtask

  task automatic compare_all();
    check("txCount",       bus.txCount,       m_q[0].size());
    check("rxCount",       bus.rxCount,       m_q[1].size());
    check("txFull",        bus.txFull,        m_q[0].size() == TXD);
    check("txEmpty",       bus.txEmpty,       m_q[0].size() == 0);
    check("txAlmostEmpty", bus.txAlmostEmpty, m_q[0].size() <= TXLOW);
    check("rxFull",        bus.rxFull,        m_q[1].size() == RXD);
    check("rxEmpty",       bus.rxEmpty,       m_q[1].size() == 0);
    check("rxAlmostFull",  bus.rxAlmostFull,  m_q[1].size() >= RXHIGH);
    check("spiTxData",     bus.spiTxData,     m_dout[0]);
    check("coreRxData",    bus.coreRxData,    m_dout[1]);
    check("txOverflow",    bus.txOverflow,    m_ovf[0]);
    check("txUnderflow",   bus.txUnderflow,   m_unf[0]);
    check("rxOverflow",    bus.rxOverflow,    m_ovf[1]);
    check("rxUnderflow",   bus.rxUnderflow,   m_unf[1]);
  endtask

  // One clock: model consumes the driven inputs, DUT takes the edge, outputs compared mid-cycle.
  task automatic step();
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        m_q[d].delete();
        m_dout[d] = '0;
        m_ovf[d]  = 1'b0;
        m_unf[d]  = 1'b0;
      end
    end else begin
      model_dir(0, bus.txFlush, bus.coreTxWrite, bus.coreTxData, bus.spiTxRead, bus.errClear);
      model_dir(1, bus.rxFlush, bus.spiRxWrite, bus.spiRxData, bus.coreRxRead, bus.errClear);
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
    idle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int bias_w, bias_r;
    idle();
    do_reset();
    check("reset_txAlmostEmpty", bus.txAlmostEmpty, 1);
    check("reset_rxEmpty",       bus.rxEmpty,       1);

    // Fill TX, then one write too many.
    for (int i = 0; i < 16; i++) begin
      bus.coreTxWrite = 1'b1; bus.coreTxData = DW'(i);
      step();
    end
    check("t1_txFull",  bus.txFull,  1);
    check("t1_txCount", bus.txCount, 16);
    bus.coreTxWrite = 1'b1; bus.coreTxData = 8'h55;
    step();
    check("t1_txOverflow", bus.txOverflow, 1);
    check("t1_txCount2",   bus.txCount,    16);

    // Drain TX in order, then one pop too many.
    for (int i = 0; i < 16; i++) begin
      bus.spiTxRead = 1'b1;
      step();
      check("t2_spiTxData", bus.spiTxData, i);
    end
    bus.spiTxRead = 1'b1;
    step();
    check("t2_txUnderflow", bus.txUnderflow, 1);
    check("t2_hold",        bus.spiTxData,   8'h0F);
    bus.errClear = 1'b1;
    step();

    // RX high watermark.
    for (int i = 0; i < 12; i++) begin
      bus.spiRxWrite = 1'b1; bus.spiRxData = DW'($urandom);
      step();
    end
    check("t3_rxAlmostFull", bus.rxAlmostFull, 1);
    bus.coreRxRead = 1'b1;
    step();
    check("t3_rxAlmostFull_off", bus.rxAlmostFull, 0);
    check("t3_rxCount",          bus.rxCount,      11);

    // Push into a full TX together with a pop.
    for (int i = 0; i < 16; i++) begin
      bus.coreTxWrite = 1'b1; bus.coreTxData = DW'($urandom);
      step();
    end
    bus.coreTxWrite = 1'b1; bus.coreTxData = 8'hA5; bus.spiTxRead = 1'b1;
    step();
    check("t4_noOverflow", bus.txOverflow, 0);
    check("t4_txCount",    bus.txCount,    16);
    for (int i = 0; i < 16; i++) begin
      bus.spiTxRead = 1'b1;
      step();
    end
    check("t4_last", bus.spiTxData, 8'hA5);

    // Pointer wrap with occupancy held at 3.
    bus.txFlush = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      bus.coreTxWrite = 1'b1; bus.coreTxData = DW'($urandom);
      step();
    end
    for (int i = 0; i < 40; i++) begin
      bus.coreTxWrite = 1'b1; bus.coreTxData = DW'($urandom); bus.spiTxRead = 1'b1;
      step();
      check("t5_count", bus.txCount, 3);
    end

    // RX flush beats a same-cycle write and clears the RX error flags.
    bus.rxFlush = 1'b1;
    step();
    bus.coreRxRead = 1'b1;
    step();
    check("t6_rxUnderflow_set", bus.rxUnderflow, 1);
    for (int i = 0; i < 5; i++) begin
      bus.spiRxWrite = 1'b1; bus.spiRxData = DW'($urandom);
      step();
    end
    bus.rxFlush = 1'b1; bus.spiRxWrite = 1'b1; bus.spiRxData = 8'h3C;
    step();
    check("t6_rxCount",     bus.rxCount,     0);
    check("t6_rxEmpty",     bus.rxEmpty,     1);
    check("t6_rxOverflow",  bus.rxOverflow,  0);
    check("t6_rxUnderflow", bus.rxUnderflow, 0);
    check("t6_txCount",     bus.txCount,     3);

    // Random traffic with drifting push/pop bias to sweep full and empty.
    bias_w = 50; bias_r = 50;
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) begin
        bias_w = $urandom_range(10, 90);
        bias_r = $urandom_range(10, 90);
      end
      bus.coreTxWrite = ($urandom_range(0, 99) < bias_w);
      bus.coreTxData  = DW'($urandom);
      bus.spiTxRead   = ($urandom_range(0, 99) < bias_r);
      bus.spiRxWrite  = ($urandom_range(0, 99) < bias_r);
      bus.spiRxData   = DW'($urandom);
      bus.coreRxRead  = ($urandom_range(0, 99) < bias_w);
      bus.txFlush     = ($urandom_range(0, 63) == 0);
      bus.rxFlush     = ($urandom_range(0, 63) == 0);
      bus.errClear    = ($urandom_range(0, 31) == 0);
      if (c == 700) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
